// File: rtl/gelato_inst_fetch.sv
// -----------------------------------------------------------------------------
// gelato_inst_fetch
//   Instruction fetch unit of the Gelato frontend. Keeps a PC and an active bit
//   per hardware warp, picks one active warp round-robin, issues a single fetch
//   to the L1 instruction cache and hands the returned instruction to decode.
//   Only one fetch is in flight at a time. Later stages can launch, retire or
//   redirect warps at any time; a fetch whose warp is touched while in flight
//   is squashed (its result is thrown away).
//
// Ports
//   clk, rst          : clock and synchronous active-high reset
//   rdy               : global enable, everything holds while low
//   launch_*          : start a warp at a given PC
//   retire_*          : deactivate a warp
//   redirect_*        : overwrite the PC of a warp (branch)
//   req_*             : fetch request to the instruction cache (valid/ready)
//   resp_valid/data   : cache answer for the outstanding request
//   out_*             : instruction, PC and warp handed to decode (valid/ready)
// -----------------------------------------------------------------------------
module gelato_inst_fetch #(
  parameter int NUM_WARPS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  localparam int WID       = $clog2(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  launch_valid,
  input  logic [WID-1:0]        launch_warp,
  input  logic [ADDR_WIDTH-1:0] launch_pc,
  input  logic                  retire_valid,
  input  logic [WID-1:0]        retire_warp,
  input  logic                  redirect_valid,
  input  logic [WID-1:0]        redirect_warp,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [WID-1:0]        req_warp,
  input  logic                  resp_valid,
  input  logic [INST_WIDTH-1:0] resp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [WID-1:0]        out_warp
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state, state_next;
  logic   squash, squash_next;

  logic [NUM_WARPS-1:0]  active;
  logic [ADDR_WIDTH-1:0] pc [NUM_WARPS];
  logic [WID-1:0]        rr_ptr;
  logic [WID-1:0]        cur_warp;
  logic [ADDR_WIDTH-1:0] cur_pc;
  logic [INST_WIDTH-1:0] inst_q;

  logic [WID-1:0] sel_warp;
  logic [WID-1:0] scan_idx;
  logic           any_active;
  logic           cur_hit;
  logic           sel_hit;
  logic           out_fire;

  // Round-robin pick: scan from the farthest offset down to offset 0 so the
  // last match written is the first active warp at or after rr_ptr.
  always_comb begin
    sel_warp   = rr_ptr;
    any_active = 1'b0;
    scan_idx   = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      scan_idx = rr_ptr + WID'(i);
      if (active[scan_idx]) begin
        sel_warp   = scan_idx;
        any_active = 1'b1;
      end
    end
  end

  // A launch, redirect or retire aimed at the warp being fetched makes the
  // fetched data stale. The same applies to the warp being picked in IDLE,
  // since its PC is latched from the value before the update lands.
  assign cur_hit = (launch_valid   && (launch_warp   == cur_warp)) ||
                   (redirect_valid && (redirect_warp == cur_warp)) ||
                   (retire_valid   && (retire_warp   == cur_warp));

  assign sel_hit = (launch_valid   && (launch_warp   == sel_warp)) ||
                   (redirect_valid && (redirect_warp == sel_warp)) ||
                   (retire_valid   && (retire_warp   == sel_warp));

  assign out_fire = (state == OUT) && out_ready;

  // State register; rdy low freezes the FSM and the squash flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      squash <= 1'b0;
    end else if (rdy) begin
      state  <= state_next;
      squash <= squash_next;
    end
  end

  // Next-state logic. A squashed request still has to complete so the cache
  // can answer; its response is then dropped in WAIT. In OUT the squash takes
  // effect immediately unless decode takes the instruction in that cycle.
  always_comb begin
    state_next  = state;
    squash_next = squash;
    case (state)
      IDLE: begin
        squash_next = 1'b0;
        if (any_active) begin
          state_next  = REQ;
          squash_next = sel_hit;
        end
      end
      REQ: begin
        if (cur_hit) squash_next = 1'b1;
        if (req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (resp_valid) begin
          squash_next = 1'b0;
          state_next  = (squash || cur_hit) ? IDLE : OUT;
        end else if (cur_hit) begin
          squash_next = 1'b1;
        end
      end
      OUT: begin
        squash_next = 1'b0;
        if (out_ready || cur_hit) state_next = IDLE;
      end
      default: begin
        state_next  = IDLE;
        squash_next = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registered state so they stay put while the
  // handshake partner stalls or rdy is low.
  always_comb begin
    req_valid = (state == REQ);
    out_valid = (state == OUT);
    req_addr  = cur_pc;
    req_warp  = cur_warp;
    out_pc    = cur_pc;
    out_warp  = cur_warp;
    out_inst  = inst_q;
  end

  // Per-warp PC/active bits and fetch datapath. Per warp the order of
  // precedence is launch, redirect, retire, then the post-delivery increment;
  // a launch also overrides a retire of the same warp.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= '0;
      rr_ptr   <= '0;
      cur_warp <= '0;
      cur_pc   <= '0;
      inst_q   <= '0;
      for (int w = 0; w < NUM_WARPS; w++) pc[w] <= '0;
    end else if (rdy) begin
      if ((state == IDLE) && any_active) begin
        cur_warp <= sel_warp;
        cur_pc   <= pc[sel_warp];
      end
      if ((state == REQ) && req_ready) rr_ptr <= cur_warp + WID'(1);
      if ((state == WAIT) && resp_valid) inst_q <= resp_data;
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (launch_valid && (launch_warp == WID'(w))) begin
          pc[w]     <= launch_pc;
          active[w] <= 1'b1;
        end else begin
          if (redirect_valid && (redirect_warp == WID'(w))) begin
            pc[w] <= redirect_pc;
          end else if (out_fire && (cur_warp == WID'(w))) begin
            pc[w] <= pc[w] + PC_STEP;
          end
          if (retire_valid && (retire_warp == WID'(w))) active[w] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gelato_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_gelato_inst_fetch
//   Self-checking bench for gelato_inst_fetch: a table of single-transaction
//   vectors, hand-written multi-cycle sequences (stalls, redirects, retire,
//   reset, rdy gating) and a randomized run against a reference model of the
//   warp scheduler kept here in the bench.
// -----------------------------------------------------------------------------
module tb_gelato_inst_fetch;

  localparam int NW  = 4;
  localparam int AW  = 32;
  localparam int IW  = 32;
  localparam int WID = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           rdy;
  logic           launch_valid;
  logic [WID-1:0] launch_warp;
  logic [AW-1:0]  launch_pc;
  logic           retire_valid;
  logic [WID-1:0] retire_warp;
  logic           redirect_valid;
  logic [WID-1:0] redirect_warp;
  logic [AW-1:0]  redirect_pc;
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  req_addr;
  logic [WID-1:0] req_warp;
  logic           resp_valid;
  logic [IW-1:0]  resp_data;
  logic           out_valid;
  logic           out_ready;
  logic [IW-1:0]  out_inst;
  logic [AW-1:0]  out_pc;
  logic [WID-1:0] out_warp;

  int checks = 0;
  int errors = 0;

  gelato_inst_fetch #(
    .NUM_WARPS (NW),
    .ADDR_WIDTH(AW),
    .INST_WIDTH(IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .launch_valid  (launch_valid),
    .launch_warp   (launch_warp),
    .launch_pc     (launch_pc),
    .retire_valid  (retire_valid),
    .retire_warp   (retire_warp),
    .redirect_valid(redirect_valid),
    .redirect_warp (redirect_warp),
    .redirect_pc   (redirect_pc),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_warp      (req_warp),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_warp      (out_warp)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic           lv;
    logic [WID-1:0] lw;
    logic [AW-1:0]  lpc;
    logic           req_ready;
    logic           resp_valid;
    logic [IW-1:0]  resp_data;
    logic           out_ready;
    logic           e_req_valid;
    logic [AW-1:0]  e_req_addr;
    logic [WID-1:0] e_req_warp;
    logic           e_out_valid;
    logic [AW-1:0]  e_out_pc;
    logic [WID-1:0] e_out_warp;
    logic [IW-1:0]  e_out_inst;
  } vec_t;

  // ---------------------------------------------------------------- helpers
  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    rdy            = 1'b1;
    launch_valid   = 1'b0;
    launch_warp    = '0;
    launch_pc      = '0;
    retire_valid   = 1'b0;
    retire_warp    = '0;
    redirect_valid = 1'b0;
    redirect_warp  = '0;
    redirect_pc    = '0;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    out_ready      = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    launch_valid = v.lv;
    launch_warp  = v.lw;
    launch_pc    = v.lpc;
    req_ready    = v.req_ready;
    resp_valid   = v.resp_valid;
    resp_data    = v.resp_data;
    out_ready    = v.out_ready;
  endtask

  task automatic resetDut();
    clearInputs();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  task automatic launchWarp(input int w, input logic [AW-1:0] p);
    launch_valid = 1'b1;
    launch_warp  = WID'(w);
    launch_pc    = p;
    nextCycle();
    launch_valid = 1'b0;
  endtask

  task automatic waitReq(input string name);
    int n = 0;
    while (!req_valid && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput(name, 64'(req_valid), 64'd1);
  endtask

  task automatic waitOut(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput(name, 64'(out_valid), 64'd1);
  endtask

  // ------------------------------------------------------- reference model
  // Transaction view of the fetch unit: warp table plus one in-flight fetch
  // record that moves through four phases.
  logic [AW-1:0] m_pc [NW];
  bit            m_act [NW];
  int            m_rr;
  int            m_phase;   // 0 choosing, 1 requesting, 2 waiting, 3 delivering
  int            m_warp;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_inst;
  bit            m_stale;

  function automatic bit touches(input int w);
    return (launch_valid && int'(launch_warp) == w) ||
           (redirect_valid && int'(redirect_warp) == w) ||
           (retire_valid && int'(retire_warp) == w);
  endfunction

  task automatic modelReset();
    for (int w = 0; w < NW; w++) begin
      m_pc[w]  = '0;
      m_act[w] = 1'b0;
    end
    m_rr = 0; m_phase = 0; m_warp = 0; m_addr = '0; m_inst = '0; m_stale = 1'b0;
  endtask

  task automatic modelStep();
    logic [AW-1:0] old_pc [NW];
    bit            old_act [NW];
    bit            hit;
    if (rst) begin
      modelReset();
      return;
    end
    if (!rdy) return;
    for (int w = 0; w < NW; w++) begin
      old_pc[w]  = m_pc[w];
      old_act[w] = m_act[w];
    end
    hit = touches(m_warp);
    // warp table, lowest priority first so later writes win
    if (m_phase == 3 && out_ready) m_pc[m_warp] = m_pc[m_warp] + 32'd4;
    if (retire_valid) m_act[retire_warp] = 1'b0;
    if (redirect_valid) m_pc[redirect_warp] = redirect_pc;
    if (launch_valid) begin
      m_pc[launch_warp]  = launch_pc;
      m_act[launch_warp] = 1'b1;
    end
    case (m_phase)
      0: begin
        for (int k = 0; k < NW; k++) begin
          int c;
          c = (m_rr + k) % NW;
          if (old_act[c]) begin
            m_warp  = c;
            m_addr  = old_pc[c];
            m_stale = touches(c);
            m_phase = 1;
            break;
          end
        end
      end
      1: begin
        if (hit) m_stale = 1'b1;
        if (req_ready) begin
          m_rr    = (m_warp + 1) % NW;
          m_phase = 2;
        end
      end
      2: begin
        if (resp_valid) begin
          m_inst  = resp_data;
          m_phase = (m_stale || hit) ? 0 : 3;
          m_stale = 1'b0;
        end else if (hit) begin
          m_stale = 1'b1;
        end
      end
      default: begin
        if (out_ready || hit) m_phase = 0;
        m_stale = 1'b0;
      end
    endcase
  endtask

  task automatic modelCheck();
    checkOutput("rnd_req_valid", 64'(req_valid), 64'(m_phase == 1));
    checkOutput("rnd_out_valid", 64'(out_valid), 64'(m_phase == 3));
    if (m_phase == 1) begin
      checkOutput("rnd_req_addr", 64'(req_addr), 64'(m_addr));
      checkOutput("rnd_req_warp", 64'(req_warp), 64'(m_warp));
    end
    if (m_phase == 3) begin
      checkOutput("rnd_out_pc", 64'(out_pc), 64'(m_addr));
      checkOutput("rnd_out_warp", 64'(out_warp), 64'(m_warp));
      checkOutput("rnd_out_inst", 64'(out_inst), 64'(m_inst));
    end
  endtask

  // ------------------------------------------------------------------ test
  vec_t vecs [7];
  int   exp_warp [6];
  logic [AW-1:0] exp_pc [6];

  initial begin
    vecs[0] = '{1'b1, 2'd2, 32'h100, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   2'd0, 1'b0, 32'h0,   2'd0, 32'h0};
    vecs[1] = '{1'b0, 2'd0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   2'd0, 1'b0, 32'h0,   2'd0, 32'h0};
    vecs[2] = '{1'b0, 2'd0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100, 2'd2, 1'b0, 32'h0,   2'd0, 32'h0};
    vecs[3] = '{1'b0, 2'd0, 32'h0,   1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,   2'd0, 1'b0, 32'h0,   2'd0, 32'h0};
    vecs[4] = '{1'b0, 2'd0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   2'd0, 1'b1, 32'h100, 2'd2, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 2'd0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   2'd0, 1'b0, 32'h0,   2'd0, 32'h0};
    vecs[6] = '{1'b0, 2'd0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h104, 2'd2, 1'b0, 32'h0,   2'd0, 32'h0};

    // reset state
    resetDut();
    checkOutput("reset_req_valid", 64'(req_valid), 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_req_addr", 64'(req_addr), 64'd0);
    checkOutput("reset_req_warp", 64'(req_warp), 64'd0);
    checkOutput("reset_out_inst", 64'(out_inst), 64'd0);
    checkOutput("reset_out_pc", 64'(out_pc), 64'd0);

    // single-warp transaction, cycle by cycle
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_req_valid", i), 64'(req_valid), 64'(vecs[i].e_req_valid));
      checkOutput($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_out_valid));
      if (vecs[i].e_req_valid) begin
        checkOutput($sformatf("vec%0d_req_addr", i), 64'(req_addr), 64'(vecs[i].e_req_addr));
        checkOutput($sformatf("vec%0d_req_warp", i), 64'(req_warp), 64'(vecs[i].e_req_warp));
      end
      if (vecs[i].e_out_valid) begin
        checkOutput($sformatf("vec%0d_out_pc", i), 64'(out_pc), 64'(vecs[i].e_out_pc));
        checkOutput($sformatf("vec%0d_out_warp", i), 64'(out_warp), 64'(vecs[i].e_out_warp));
        checkOutput($sformatf("vec%0d_out_inst", i), 64'(out_inst), 64'(vecs[i].e_out_inst));
      end
      nextCycle();
    end

    // round robin over warps 0,1,3 with everything always ready
    resetDut();
    req_ready = 1'b1; out_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'hA5A5_0000;
    launchWarp(0, 32'h0);
    launchWarp(1, 32'h1000);
    launchWarp(3, 32'h3000);
    exp_warp = '{0, 1, 3, 0, 1, 3};
    exp_pc   = '{32'h0, 32'h1000, 32'h3000, 32'h4, 32'h1004, 32'h3004};
    for (int n = 0; n < 6; n++) begin
      waitOut($sformatf("rr_out_seen%0d", n));
      checkOutput($sformatf("rr_out_warp%0d", n), 64'(out_warp), 64'(exp_warp[n]));
      checkOutput($sformatf("rr_out_pc%0d", n), 64'(out_pc), 64'(exp_pc[n]));
      nextCycle();
    end

    // cache and decode back-pressure
    resetDut();
    launchWarp(1, 32'h40);
    waitReq("stall_req_seen");
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_req_valid", 64'(req_valid), 64'd1);
      checkOutput("stall_req_addr", 64'(req_addr), 64'h40);
      checkOutput("stall_req_warp", 64'(req_warp), 64'd1);
      nextCycle();
    end
    req_ready = 1'b1; nextCycle(); req_ready = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h1234_5678; nextCycle(); resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_out_pc", 64'(out_pc), 64'h40);
      checkOutput("stall_out_inst", 64'(out_inst), 64'h1234_5678);
      nextCycle();
    end
    out_ready = 1'b1; nextCycle(); out_ready = 1'b0;
    waitReq("stall_next_req_seen");
    checkOutput("stall_next_addr", 64'(req_addr), 64'h44);

    // redirect while waiting for the cache, then redirect at the handshake
    resetDut();
    launchWarp(0, 32'h200);
    waitReq("redir_req_seen");
    checkOutput("redir_first_addr", 64'(req_addr), 64'h200);
    req_ready = 1'b1; nextCycle(); req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_warp = 2'd0; redirect_pc = 32'h800;
    nextCycle();
    redirect_valid = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h0000_0BAD; nextCycle(); resp_valid = 1'b0;
    begin
      bit seen_out = 1'b0;
      int n = 0;
      while (!req_valid && n < 10) begin
        if (out_valid) seen_out = 1'b1;
        nextCycle();
        n++;
      end
      checkOutput("redir_dropped", 64'(seen_out), 64'd0);
    end
    checkOutput("redir_req_valid", 64'(req_valid), 64'd1);
    checkOutput("redir_new_addr", 64'(req_addr), 64'h800);
    checkOutput("redir_new_warp", 64'(req_warp), 64'd0);
    req_ready = 1'b1; nextCycle(); req_ready = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h00C0_FFEE; nextCycle(); resp_valid = 1'b0;
    checkOutput("redir_hs_out_valid", 64'(out_valid), 64'd1);
    checkOutput("redir_hs_out_inst", 64'(out_inst), 64'h00C0_FFEE);
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_warp = 2'd0; redirect_pc = 32'h800;
    nextCycle();
    out_ready = 1'b0; redirect_valid = 1'b0;
    checkOutput("redir_hs_out_done", 64'(out_valid), 64'd0);
    waitReq("redir_hs_next_seen");
    checkOutput("redir_hs_next_addr", 64'(req_addr), 64'h800);

    // retire the only warp mid-fetch
    resetDut();
    launchWarp(3, 32'h300);
    waitReq("retire_req_seen");
    req_ready = 1'b1; nextCycle(); req_ready = 1'b0;
    retire_valid = 1'b1; retire_warp = 2'd3; nextCycle(); retire_valid = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h3333_3333; nextCycle(); resp_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("retire_req_valid", 64'(req_valid), 64'd0);
      checkOutput("retire_out_valid", 64'(out_valid), 64'd0);
      nextCycle();
    end

    // reset while presenting an instruction
    launchWarp(1, 32'h10);
    waitReq("rstout_req_seen");
    req_ready = 1'b1; nextCycle(); req_ready = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h0101_0101; nextCycle(); resp_valid = 1'b0;
    checkOutput("rstout_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; nextCycle(); rst = 1'b0;
    checkOutput("rstout_out_dropped", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("rstout_idle", 64'(req_valid), 64'd0);
      nextCycle();
    end

    // rdy low in REQ, WAIT and OUT freezes everything
    resetDut();
    launchWarp(2, 32'h500);
    waitReq("rdy_req_seen");
    req_ready = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("rdy_req_held", 64'(req_valid), 64'd1);
      checkOutput("rdy_req_addr", 64'(req_addr), 64'h500);
    end
    rdy = 1'b1; nextCycle(); req_ready = 1'b0;
    resp_valid = 1'b1; resp_data = 32'h0000_55AA; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("rdy_wait_held", 64'(out_valid), 64'd0);
      checkOutput("rdy_wait_noreq", 64'(req_valid), 64'd0);
    end
    rdy = 1'b1; nextCycle(); resp_valid = 1'b0;
    out_ready = 1'b1; rdy = 1'b0;
    redirect_valid = 1'b1; redirect_warp = 2'd2; redirect_pc = 32'h999;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("rdy_out_held", 64'(out_valid), 64'd1);
      checkOutput("rdy_out_inst", 64'(out_inst), 64'h0000_55AA);
      checkOutput("rdy_out_pc", 64'(out_pc), 64'h500);
    end
    redirect_valid = 1'b0; rdy = 1'b1;
    nextCycle(); out_ready = 1'b0;
    waitReq("rdy_next_seen");
    checkOutput("rdy_next_addr", 64'(req_addr), 64'h504);
    checkOutput("rdy_next_warp", 64'(req_warp), 64'd2);

    // randomized run against the reference model
    resetDut();
    modelReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      modelCheck();
      rst            = ($urandom_range(0, 299) == 0);
      rdy            = ($urandom_range(0, 9) != 0);
      launch_valid   = ($urandom_range(0, 7) == 0);
      launch_warp    = WID'($urandom_range(0, NW - 1));
      launch_pc      = $urandom;
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_warp  = WID'($urandom_range(0, NW - 1));
      redirect_pc    = $urandom;
      retire_valid   = ($urandom_range(0, 15) == 0);
      retire_warp    = WID'($urandom_range(0, NW - 1));
      req_ready      = ($urandom_range(0, 3) != 0);
      resp_valid     = ($urandom_range(0, 1) == 1);
      resp_data      = $urandom;
      out_ready      = ($urandom_range(0, 4) > 1);
      modelStep();
      nextCycle();
    end
    clearInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
